// File: rtl/i2s_sample_fifo_pkg.sv
// Shared types and constants for the I2S sample FIFO slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package i2s_pkg;

  localparam int DEFAULT_DATA_SIZE = 16;
  localparam int OVF_CNT_W         = 16;

  // Sample type at the default receiver width; wider builds use their own DATA_SIZE.
  typedef logic [DEFAULT_DATA_SIZE-1:0] sample_t;

  localparam logic [OVF_CNT_W-1:0] OVF_CNT_MAX = {OVF_CNT_W{1'b1}};

endpackage

// File: rtl/i2s_sample_fifo_core.sv
// sync_fifo_core: power-of-two register-array FIFO with extended pointers and level.
// Latency: written word visible on rd_data the cycle after the push edge (FWFT).
// Backpressure: caller qualifies push/pop; core trusts them (no internal guarding).
// Ports: clk/rst (sync, active high); push/wr_data write side; pop/rd_data read side;
//        empty/full flags; level (registered occupancy) and level_next (its D input).
module sync_fifo_core #(
  parameter int DATA_SIZE = 16,
  parameter int DEPTH     = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [DATA_SIZE-1:0]       wr_data,
  input  logic                       pop,
  output logic [DATA_SIZE-1:0]       rd_data,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     level,
  output logic [$clog2(DEPTH):0]     level_next
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]        level_q, level_d;
  logic [DATA_SIZE-1:0] mem_q [DEPTH];

  // Extra pointer MSB separates the full case from the empty case.
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   level_d = level_q + PW'(1);
      2'b01:   level_d = level_q - PW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage is deliberately not reset; stale words are hidden by the pointers.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

  assign level      = level_q;
  // Reset forces level to zero, so the watermark flop must see that too.
  assign level_next = rst ? '0 : level_d;

endmodule

// File: rtl/i2s_sample_fifo.sv
// i2s_sample_fifo: buffers strobed PCM samples onto a valid/ready stream with level/watermark/overflow.
// Latency: 1 cycle strobe-to-out_valid into an empty FIFO (first-word fall-through).
// Backpressure: strobe cannot stall; a strobe while full with no pop is dropped and flagged.
// Ports: clk, rst (sync, active high); in_valid/in_data strobe input; out_valid/out_ready/out_data
//        stream output; level, almost_full; overflow (sticky), overflow_clr, overflow_count.
// Build option: define I2S_FIFO_STATS_EN to get a saturating dropped-sample counter.
module i2s_sample_fifo
  import i2s_pkg::*;
#(
  parameter int DATA_SIZE = DEFAULT_DATA_SIZE,
  parameter int DEPTH     = 64,
  parameter int WATERMARK = 48
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [DATA_SIZE-1:0]   in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_SIZE-1:0]   out_data,
  output logic [$clog2(DEPTH):0] level,
  output logic                   almost_full,
  output logic                   overflow,
  input  logic                   overflow_clr,
  output logic [OVF_CNT_W-1:0]   overflow_count
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic          empty, full, push, pop, drop;
  logic [LW-1:0] level_next;
  logic          almost_full_q, almost_full_d;
  logic          overflow_q, overflow_d;

  assign pop  = !empty && out_ready;
  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign push = in_valid && (!full || pop);
  assign drop = in_valid && full && !pop;

  sync_fifo_core #(
    .DATA_SIZE (DATA_SIZE),
    .DEPTH     (DEPTH)
  ) u_core (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .wr_data    (in_data),
    .pop        (pop),
    .rd_data    (out_data),
    .empty      (empty),
    .full       (full),
    .level      (level),
    .level_next (level_next)
  );

  always_comb begin
    almost_full_d = (level_next >= LW'(WATERMARK));
    overflow_d    = overflow_q;
    if (overflow_clr) overflow_d = 1'b0;
    if (drop)         overflow_d = 1'b1;  // set beats clear
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      almost_full_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      almost_full_q <= almost_full_d;
      overflow_q    <= overflow_d;
    end
  end

  assign out_valid   = !empty;
  assign almost_full = almost_full_q;
  assign overflow    = overflow_q;

`ifdef I2S_FIFO_STATS_EN
  logic [OVF_CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;

  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    if (overflow_clr)
      ovf_cnt_d = drop ? OVF_CNT_W'(1) : '0;
    else if (drop && ovf_cnt_q != OVF_CNT_MAX)
      ovf_cnt_d = ovf_cnt_q + OVF_CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) ovf_cnt_q <= '0;
    else     ovf_cnt_q <= ovf_cnt_d;
  end

  assign overflow_count = ovf_cnt_q;
`else
  assign overflow_count = '0;
`endif

endmodule

// File: tb/tb_i2s_sample_fifo.sv
// Testbench for i2s_sample_fifo: scoreboard of accepted samples plus a flag/counter model.
// Latency: n/a.
// Backpressure: n/a.
module tb_i2s_sample_fifo;
  localparam int DS = 16;
  localparam int DEPTH = 64;
  localparam int WM = 48;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [DS-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DS-1:0] out_data;
  logic [6:0]    level;
  logic          almost_full;
  logic          overflow;
  logic          overflow_clr = 1'b0;
  logic [15:0]   overflow_count;

  always #5 clk = ~clk;

  i2s_sample_fifo #(.DATA_SIZE(DS), .DEPTH(DEPTH), .WATERMARK(WM)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_data        (in_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .level          (level),
    .almost_full    (almost_full),
    .overflow       (overflow),
    .overflow_clr   (overflow_clr),
    .overflow_count (overflow_count)
  );

  int n_chk  = 0;
  int n_pass = 0;

  logic [DS-1:0] sbq[$];
  logic          m_ovf = 1'b0;
  logic [15:0]   m_cnt = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // One clock: inputs driven at negedge, model updated, ends just after the posedge.
  task automatic cycle(input logic v, input logic [DS-1:0] d, input logic rdy, input logic clr);
    logic m_pop, m_full, m_push, m_drop;
    logic [DS-1:0] exp;
    @(negedge clk);
    in_valid = v; in_data = d; out_ready = rdy; overflow_clr = clr;
    m_pop  = (sbq.size() != 0) && rdy;
    m_full = (sbq.size() == DEPTH);
    m_push = v && (!m_full || m_pop);
    m_drop = v && m_full && !m_pop;
    if (m_pop) begin
      exp = sbq.pop_front();
      chk("rd_data", 32'(out_data), 32'(exp));
    end
    if (m_push) sbq.push_back(d);
    if (clr) m_ovf = 1'b0;
    if (m_drop) m_ovf = 1'b1;
`ifdef I2S_FIFO_STATS_EN
    if (clr) m_cnt = m_drop ? 16'd1 : 16'd0;
    else if (m_drop && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
`endif
    @(posedge clk);
    #1;
    in_valid = 1'b0; out_ready = 1'b0; overflow_clr = 1'b0;
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".level"}, 32'(level), 32'(sbq.size()));
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(sbq.size() != 0));
    chk({tag, ".almost_full"}, 32'(almost_full), 32'(sbq.size() >= WM));
    chk({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
    chk({tag, ".count"}, 32'(overflow_count), 32'(m_cnt));
    if (sbq.size() != 0) chk({tag, ".head"}, 32'(out_data), 32'(sbq[0]));
  endtask

  task automatic do_reset(input logic v_during);
    @(negedge clk);
    rst = 1'b1; in_valid = v_during; in_data = 16'hDEAD; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    sbq.delete(); m_ovf = 1'b0; m_cnt = '0;
    #1;
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    do_reset(1'b0);
    check_state("reset");

    // Three samples, first-cycle latency, then in-order drain
    cycle(1'b1, 16'h0001, 1'b0, 1'b0);
    chk("lat.out_valid", 32'(out_valid), 32'd1);
    chk("lat.out_data", 32'(out_data), 32'h0001);
    cycle(1'b1, 16'h0002, 1'b0, 1'b0);
    cycle(1'b1, 16'h0003, 1'b0, 1'b0);
    check_state("three");
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, 1'b0);
    check_state("drained3");

    // Watermark and fill
    for (int i = 0; i < WM; i++) begin
      cycle(1'b1, 16'(16'h0100 + i), 1'b0, 1'b0);
      if (i == WM - 2) check_state("wm_minus1");
    end
    check_state("wm");
    for (int i = WM; i < DEPTH; i++) cycle(1'b1, 16'(16'h0100 + i), 1'b0, 1'b0);
    check_state("full");
    cycle(1'b1, 16'hBEEF, 1'b0, 1'b0);
    check_state("drop1");

    // Clear, then push+pop while full
    cycle(1'b0, '0, 1'b0, 1'b1);
    check_state("clr1");
    cycle(1'b1, 16'hCAFE, 1'b1, 1'b0);
    check_state("full_pp");
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, '0, 1'b1, 1'b0);
    check_state("drain64");

    // Clear coinciding with a drop
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 16'(16'h2000 + i), 1'b0, 1'b0);
    cycle(1'b1, 16'h5555, 1'b0, 1'b0);
    check_state("drop_a");
    cycle(1'b1, 16'h6666, 1'b0, 1'b1);
    check_state("clr_and_drop");
    cycle(1'b0, '0, 1'b0, 1'b1);
    check_state("clr_alone");

    // Counter saturation
    for (int i = 0; i < 70000; i++) cycle(1'b1, 16'h7777, 1'b0, 1'b0);
    check_state("sat");
`ifdef I2S_FIFO_STATS_EN
    chk("sat.value", 32'(overflow_count), 32'h0000FFFF);
`else
    chk("sat.value", 32'(overflow_count), 32'h0);
`endif
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, '0, 1'b1, 1'b0);

    // Mid-stream reset with a strobe pending
    for (int i = 0; i < 10; i++) cycle(1'b1, 16'(16'h3000 + i), 1'b0, 1'b0);
    check_state("fill10");
    do_reset(1'b1);
    check_state("midreset");
    cycle(1'b1, 16'h1234, 1'b0, 1'b0);
    check_state("post_reset");
    cycle(1'b0, '0, 1'b1, 1'b0);
    check_state("end");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
